// File: rtl/div_8_4.sv
// div_8_4: sequential restoring divider.
// Divides an 8-bit dividend by a 4-bit divisor and produces one quotient bit per clock.
// It uses the same init/done handshake as the mult_4 shift-add multiplier, so the two can be
// chained to check a product.
// A divisor of zero is answered at once with all-ones results and the dz flag set.
module div_8_4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          done,
    output logic          dz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic            init_q;
    logic [DW-1:0]   qr;
    logic [VW:0]     rem;
    logic [VW-1:0]   dv;
    logic [CW-1:0]   cnt;

    logic            start;
    logic            step_bit;
    logic [VW:0]     step_rem;

    // One restoring step: trial-subtract the divisor from the shifted partial remainder.
    // A negative difference means the subtraction borrowed, so the shifted value is kept and
    // the quotient bit is 0.
    // The partial remainder is always below the divisor, so the shifted value fits in VW+1 bits.
    function automatic logic [VW+1:0] restore_step(input logic [VW:0] sh,
                                                   input logic [VW-1:0] d);
        logic signed [VW+1:0] diff;
        diff = $signed({1'b0, sh}) - $signed({2'b00, d});
        if (diff >= 0)
            restore_step = {1'b1, diff[VW:0]};
        else
            restore_step = {1'b0, sh};
    endfunction

    // Detect the start condition and evaluate the current iteration's trial subtraction.
    always_comb begin
        start = init & ~init_q & (state == IDLE);
        {step_bit, step_rem} = restore_step({rem[VW-1:0], qr[DW-1]}, dv);
    end

    // Delayed copy of init for rising-edge detection; it clears on reset, so an init held
    // high through reset counts as a fresh edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            init_q <= 1'b0;
        else
            init_q <= init;
    end

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            qr    <= '0;
            rem   <= '0;
            dv    <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (B == '0) begin
                            q     <= '1;
                            r     <= '1;
                            dz    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            qr    <= A;
                            rem   <= '0;
                            dv    <= B;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    qr  <= {qr[DW-2:0], step_bit};
                    rem <= step_rem;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        q     <= {qr[DW-2:0], step_bit};
                        r     <= step_rem[VW-1:0];
                        dz    <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_8_4.sv
// tb_div_8_4: scoreboard bench for the restoring divider.
module tb_div_8_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       init;
    logic [7:0] A;
    logic [3:0] B;
    logic [7:0] q;
    logic [3:0] r;
    logic       done;
    logic       dz;

    always #5 clk = ~clk;

    div_8_4 dut (
        .clk (clk),
        .rst (rst),
        .init(init),
        .A   (A),
        .B   (B),
        .q   (q),
        .r   (r),
        .done(done),
        .dz  (dz)
    );

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         start;
    } exp_t;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         cyc;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every done pulse together with the cycle it appeared in.
    always @(negedge clk) begin
        if (done === 1'b1) obs_q.push_back('{q, r, dz, cyc});
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one operation and push its expected result.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b, input int hold);
        exp_t e;
        A = a;
        B = b;
        init = 1'b1;
        e.a = a;
        e.b = b;
        e.start = cyc + 1;
        if (b == 4'd0) begin
            e.q = 8'hFF;
            e.r = 4'hF;
            e.dz = 1'b1;
        end else begin
            e.q = a / {4'd0, b};
            e.r = 4'(a % {4'd0, b});
            e.dz = 1'b0;
        end
        exp_q.push_back(e);
        repeat (hold) step;
        init = 1'b0;
        step;
    endtask

    // Wait for the next result, then compare it against the oldest expectation.
    task automatic check_result(input string name);
        exp_t e;
        obs_t o;
        int   n;
        int   lat;
        n = 0;
        while (obs_q.size() == 0 && n < 40) begin
            step;
            n++;
        end
        e = exp_q.pop_front();
        tests++;
        if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL %s done: none within 40 cycles, required one (A=%0d B=%0d)", name, e.a, e.b);
        end else begin
            o = obs_q.pop_front();
            tests++;
            if (o.q !== e.q) begin
                fails++;
                $display("FAIL %s q: got %h required %h (A=%0d B=%0d)", name, o.q, e.q, e.a, e.b);
            end
            tests++;
            if (o.r !== e.r) begin
                fails++;
                $display("FAIL %s r: got %h required %h (A=%0d B=%0d)", name, o.r, e.r, e.a, e.b);
            end
            tests++;
            if (o.dz !== e.dz) begin
                fails++;
                $display("FAIL %s dz: got %b required %b", name, o.dz, e.dz);
            end
            lat = o.cyc - e.start;
            tests++;
            if (e.dz) begin
                if (lat != 0 && lat != 1) begin
                    fails++;
                    $display("FAIL %s latency: got %0d required 0..1", name, lat);
                end
            end else if (lat != 8) begin
                fails++;
                $display("FAIL %s latency: got %0d required 8", name, lat);
            end
            if (!e.dz) begin
                tests++;
                if ((int'(o.q) * int'(e.b) + int'(o.r) != int'(e.a)) || (o.r >= e.b)) begin
                    fails++;
                    $display("FAIL %s invariant: q=%0d r=%0d do not satisfy A=%0d B=%0d",
                             name, o.q, o.r, e.a, e.b);
                end
            end
        end
    endtask

    // Check that no extra done pulse shows up over the given window.
    task automatic check_quiet(input string name, input int cycles);
        repeat (cycles) step;
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL %s extra done pulses: got %0d required 0", name, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        init = 1'b0;
        A = 8'd0;
        B = 4'd0;
        #1 rst = 1'b0;
        #1;
        tests++;
        if (q !== 8'd0) begin fails++; $display("FAIL reset q: got %h required 00", q); end
        tests++;
        if (r !== 4'd0) begin fails++; $display("FAIL reset r: got %h required 0", r); end
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %b required 0", done); end
        tests++;
        if (dz !== 1'b0) begin fails++; $display("FAIL reset dz: got %b required 0", dz); end
        repeat (2) step;
        rst = 1'b1;
        step;
    endtask

    task automatic test_nominal;
        do_op(8'h41, 4'hD, 2);
        check_result("nominal");
        check_quiet("nominal_single", 5);
    endtask

    task automatic test_full_width;
        do_op(8'hFF, 4'h1, 1);
        check_result("full_ff_1");
        do_op(8'd100, 4'd7, 1);
        check_result("100_7");
        do_op(8'd3, 4'hF, 1);
        check_result("3_15");
    endtask

    task automatic test_div_zero;
        do_op(8'h41, 4'h0, 1);
        check_result("div_zero");
        do_op(8'd50, 4'd5, 1);
        check_result("after_div_zero");
    endtask

    task automatic test_handshake;
        do_op(8'd10, 4'd3, 20);
        check_result("hold_init");
        check_quiet("hold_single", 5);
        do_op(8'd100, 4'd7, 1);
        A = 8'd5;
        B = 4'd1;
        init = 1'b1;
        step;
        init = 1'b0;
        step;
        init = 1'b1;
        step;
        init = 1'b0;
        step;
        check_result("toggle_in_calc");
        check_quiet("toggle_no_extra", 15);
        tests++;
        if (q !== 8'd14 || r !== 4'd2) begin
            fails++;
            $display("FAIL hold_outputs: got q=%0d r=%0d required q=14 r=2", q, r);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        A = 8'h41;
        B = 4'hD;
        init = 1'b1;
        k = cyc + 1;
        step;
        init = 1'b0;
        while (cyc < k + 4) step;
        #2 rst = 1'b0;
        #1;
        tests++;
        if (q !== 8'd0) begin fails++; $display("FAIL midreset q: got %h required 00", q); end
        tests++;
        if (r !== 4'd0) begin fails++; $display("FAIL midreset r: got %h required 0", r); end
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL midreset done: got %b required 0", done); end
        tests++;
        if (dz !== 1'b0) begin fails++; $display("FAIL midreset dz: got %b required 0", dz); end
        repeat (2) step;
        rst = 1'b1;
        check_quiet("midreset_no_done", 12);
        do_op(8'd200, 4'd9, 1);
        check_result("after_midreset");
    endtask

    task automatic test_random;
        logic [7:0] a;
        logic [3:0] b;
        for (int i = 0; i < 500; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 4'($urandom_range(1, 15));
            do_op(a, b, int'($urandom_range(1, 3)));
            check_result("random");
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_full_width;
        test_div_zero;
        test_handshake;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
